// File: rtl/calculator_pkg.sv
// Shared sizing constants for the calculator datapath and its result memories.
package calculator_pkg;
   localparam int ADDR_W        = 9;
   localparam int MEM_WORD_SIZE = 64;
endpackage

// File: rtl/result_streamer_if.sv
// Signal bundle between result_streamer, its control master, the result SRAM
// port 1 and the downstream word consumer.
interface result_streamer_if;
   import calculator_pkg::*;

   logic                        start_i;
   logic [ADDR_W-1:0]           start_addr_i;
   logic [ADDR_W-1:0]           end_addr_i;
   logic                        csb_o;
   logic [ADDR_W-1:0]           r_addr_o;
   logic [MEM_WORD_SIZE-33:0]   r_data_a_i;
   logic [31:0]                 r_data_b_i;
   logic                        m_valid_o;
   logic                        m_ready_i;
   logic [MEM_WORD_SIZE-1:0]    m_data_o;
   logic                        m_last_o;
   logic                        busy_o;
   logic                        done_o;
   logic                        err_o;

   modport slave (
      input  start_i, start_addr_i, end_addr_i, r_data_a_i, r_data_b_i, m_ready_i,
      output csb_o, r_addr_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o, err_o
   );

   modport master (
      output start_i, start_addr_i, end_addr_i, r_data_a_i, r_data_b_i, m_ready_i,
      input  csb_o, r_addr_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/result_streamer.sv
// Drains an inclusive address range of the split result SRAMs into a
// valid/ready word stream through a 2-entry FIFO, one word per cycle when unstalled.
module result_streamer
   import calculator_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   result_streamer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                   state_r;
   state_t                   state_s;
   logic [ADDR_W:0]          ptr_r;
   logic [ADDR_W:0]          end_r;
   logic [ADDR_W-1:0]        addr_hold_r;
   logic                     rd_valid_r;
   logic                     rd_last_r;
   logic                     err_r;
   logic [MEM_WORD_SIZE:0]   fifo_r [2];
   logic                     rd_idx_r;
   logic                     wr_idx_r;
   logic [1:0]               count_r;

   logic                     start_ok_s;
   logic                     accept_s;
   logic                     valid_s;
   logic                     pop_s;
   logic                     head_last_s;
   logic [1:0]               pending_s;
   logic                     issue_s;
   logic                     last_issue_s;

   // Handshake, credit and read-issue decisions for the current cycle.
   always_comb begin
      start_ok_s   = (bus.end_addr_i >= bus.start_addr_i);
      accept_s     = (state_r == IDLE) && bus.start_i;
      valid_s      = (count_r != 2'd0);
      pop_s        = valid_s && bus.m_ready_i;
      head_last_s  = fifo_r[rd_idx_r][MEM_WORD_SIZE];
      // Slots committed once this cycle's transfer frees one; a read is only
      // issued when its data is guaranteed a slot on return.
      pending_s    = count_r + {1'b0, rd_valid_r} - {1'b0, pop_s};
      issue_s      = (state_r == READ) && (pending_s < 2'd2);
      last_issue_s = issue_s && (ptr_r == end_r);
   end

   // Next-state logic for the drain sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start_i) begin
               state_s = start_ok_s ? READ : DONE;
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            if (last_issue_s) begin
               state_s = DRAIN;
            end else begin
               state_s = READ;
            end
         end
         DRAIN: begin
            if (pop_s && head_last_s) begin
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Range capture, read pointer, in-flight tracking and error flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_r       <= '0;
         end_r       <= '0;
         addr_hold_r <= '0;
         rd_valid_r  <= 1'b0;
         rd_last_r   <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         rd_valid_r <= issue_s;
         rd_last_r  <= last_issue_s;
         if (accept_s) begin
            ptr_r <= {1'b0, bus.start_addr_i};
            end_r <= {1'b0, bus.end_addr_i};
            err_r <= ~start_ok_s;
         end else if (issue_s) begin
            // Extra pointer bit lets the top address finish without wrapping to 0.
            ptr_r       <= ptr_r + {{ADDR_W{1'b0}}, 1'b1};
            addr_hold_r <= ptr_r[ADDR_W-1:0];
         end
      end
   end

   // Output FIFO: captures SRAM data exactly one cycle after its read was issued.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fifo_r[0] <= '0;
         fifo_r[1] <= '0;
         rd_idx_r  <= 1'b0;
         wr_idx_r  <= 1'b0;
         count_r   <= 2'd0;
      end else begin
         if (rd_valid_r) begin
            fifo_r[wr_idx_r] <= {rd_last_r, bus.r_data_a_i, bus.r_data_b_i};
            wr_idx_r         <= ~wr_idx_r;
         end
         if (pop_s) begin
            rd_idx_r <= ~rd_idx_r;
         end
         count_r <= count_r + {1'b0, rd_valid_r} - {1'b0, pop_s};
      end
   end

   assign bus.csb_o     = ~issue_s;
   assign bus.r_addr_o  = issue_s ? ptr_r[ADDR_W-1:0] : addr_hold_r;
   assign bus.m_valid_o = valid_s;
   assign bus.m_data_o  = fifo_r[rd_idx_r][MEM_WORD_SIZE-1:0];
   assign bus.m_last_o  = head_last_s;
   assign bus.busy_o    = (state_r == READ) || (state_r == DRAIN);
   assign bus.done_o    = (state_r == DONE);
   assign bus.err_o     = err_r;

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: SRAM model with SRAM[i] = {i, ~i},
// stream monitor, and one task per scenario.
module tb_result_streamer;
   import calculator_pkg::*;

   logic clk;
   logic rst;

   result_streamer_if bus ();

   result_streamer dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [ADDR_W-1:0]        issued_q [$];
   logic [MEM_WORD_SIZE:0]   xfer_q   [$];
   int                       valid_cnt = 0;
   int                       stab_viol = 0;
   int                       occ_viol  = 0;
   int                       hold_viol = 0;
   int                       occ_m     = 0;
   int                       infl_m    = 0;
   logic                     prev_stall = 1'b0;
   logic [MEM_WORD_SIZE:0]   prev_word  = '0;
   logic [ADDR_W-1:0]        last_addr_m = '0;

   function automatic logic [MEM_WORD_SIZE-1:0] sram_word(input logic [ADDR_W-1:0] a);
      logic [31:0] v;
      v = 32'(a);
      return {v, ~v};
   endfunction

   // SRAM port 1: data only in the cycle after a selected read, garbage otherwise.
   always @(posedge clk) begin
      if (bus.csb_o == 1'b0) begin
         {bus.r_data_a_i, bus.r_data_b_i} <= sram_word(bus.r_addr_o);
      end else begin
         {bus.r_data_a_i, bus.r_data_b_i} <= {32'hDEAD_BEEF, 32'hBAD0_BAD0};
      end
   end

   // Stream monitor: logs reads and transfers, tracks stalls and slot credit.
   always @(negedge clk) begin
      if (rst) begin
         occ_m       <= 0;
         infl_m      <= 0;
         prev_stall  <= 1'b0;
         last_addr_m <= '0;
      end else begin
         if (bus.csb_o == 1'b0) begin
            issued_q.push_back(bus.r_addr_o);
            if (occ_m + infl_m - int'(bus.m_valid_o && bus.m_ready_i) >= 2) occ_viol <= occ_viol + 1;
            last_addr_m <= bus.r_addr_o;
         end else if (bus.r_addr_o !== last_addr_m) begin
            hold_viol <= hold_viol + 1;
         end
         if (bus.m_valid_o) valid_cnt <= valid_cnt + 1;
         if (bus.m_valid_o && bus.m_ready_i) xfer_q.push_back({bus.m_last_o, bus.m_data_o});
         if (prev_stall && (!bus.m_valid_o || ({bus.m_last_o, bus.m_data_o} !== prev_word)))
            stab_viol <= stab_viol + 1;
         prev_stall <= bus.m_valid_o && !bus.m_ready_i;
         prev_word  <= {bus.m_last_o, bus.m_data_o};
         occ_m      <= occ_m + infl_m - int'(bus.m_valid_o && bus.m_ready_i);
         infl_m     <= (bus.csb_o == 1'b0) ? 1 : 0;
      end
   end

   task automatic pulse_start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
      @(posedge clk); #1;
      bus.start_addr_i = s;
      bus.end_addr_i   = e;
      bus.start_i      = 1'b1;
      @(posedge clk); #1;
      bus.start_i      = 1'b0;
   endtask

   task automatic wait_done(input int bound, input bit toggle, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (bus.done_o) begin
            ok = 1'b1;
            break;
         end
         if (toggle) begin
            @(posedge clk); #1;
            bus.m_ready_i = ~bus.m_ready_i;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({bus.csb_o, bus.m_valid_o, bus.m_last_o, bus.busy_o, bus.done_o, bus.err_o} !== 6'b100000)
         $display("FAIL reset_flags: got %b want 100000", {bus.csb_o, bus.m_valid_o, bus.m_last_o, bus.busy_o, bus.done_o, bus.err_o});
      else n_pass++;
      n_checks++;
      if (bus.r_addr_o !== 9'h000) $display("FAIL reset_addr: got %h want 000", bus.r_addr_o);
      else n_pass++;
      n_checks++;
      if (bus.m_data_o !== 64'h0) $display("FAIL reset_data: got %h want 0", bus.m_data_o);
      else n_pass++;
   endtask

   task automatic test_stream();
      int lat;
      logic [MEM_WORD_SIZE:0] exp_w;
      issued_q.delete();
      bus.m_ready_i = 1'b1;
      pulse_start(9'h010, 9'h013);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.m_valid_o) break;
         lat++;
      end
      n_checks++;
      if (lat !== 2) $display("FAIL stream_latency: got %0d cycles want 2", lat);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         exp_w = {(k == 3), sram_word(9'(9'h010 + k))};
         n_checks++;
         if (!bus.m_valid_o || ({bus.m_last_o, bus.m_data_o} !== exp_w))
            $display("FAIL stream_word%0d: got valid=%b %h want valid=1 %h", k, bus.m_valid_o, {bus.m_last_o, bus.m_data_o}, exp_w);
         else n_pass++;
         @(negedge clk);
      end
      n_checks++;
      if ({bus.done_o, bus.busy_o, bus.m_valid_o} !== 3'b100)
         $display("FAIL stream_done: got done/busy/valid=%b want 100", {bus.done_o, bus.busy_o, bus.m_valid_o});
      else n_pass++;
      @(negedge clk); #1;
      n_checks++;
      if (bus.done_o !== 1'b0) $display("FAIL stream_done_pulse: got %b want 0", bus.done_o);
      else n_pass++;
      n_checks++;
      if (issued_q.size() != 4 || issued_q[0] !== 9'h010 || issued_q[3] !== 9'h013)
         $display("FAIL stream_reads: got %0d reads want 4 (010..013)", issued_q.size());
      else n_pass++;
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [MEM_WORD_SIZE:0] exp_w;
      issued_q.delete();
      xfer_q.delete();
      bus.m_ready_i = 1'b1;
      pulse_start(9'h010, 9'h013);
      wait_done(80, 1'b1, ok);
      #1;
      n_checks++;
      if (!ok) $display("FAIL bp_timeout: got no done_o want done_o within 80 cycles");
      else n_pass++;
      n_checks++;
      if (xfer_q.size() != 4) $display("FAIL bp_count: got %0d words want 4", xfer_q.size());
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         exp_w = {(k == 3), sram_word(9'(9'h010 + k))};
         n_checks++;
         if (k >= xfer_q.size() || xfer_q[k] !== exp_w)
            $display("FAIL bp_word%0d: got %h want %h", k, (k < xfer_q.size()) ? xfer_q[k] : 65'h0, exp_w);
         else n_pass++;
      end
      n_checks++;
      if (stab_viol != 0 || occ_viol != 0 || hold_viol != 0)
         $display("FAIL bp_rules: got stall=%0d credit=%0d addr_hold=%0d violations want 0", stab_viol, occ_viol, hold_viol);
      else n_pass++;
      n_checks++;
      if (issued_q.size() != 4) $display("FAIL bp_reads: got %0d want 4", issued_q.size());
      else n_pass++;
      bus.m_ready_i = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_top_addr();
      bit ok;
      issued_q.delete();
      xfer_q.delete();
      pulse_start(9'h1FF, 9'h1FF);
      wait_done(20, 1'b0, ok);
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (!ok || xfer_q.size() != 1 || xfer_q[0] !== {1'b1, sram_word(9'h1FF)})
         $display("FAIL top_word: got done=%b n=%0d want one last word %h", ok, xfer_q.size(), {1'b1, sram_word(9'h1FF)});
      else n_pass++;
      n_checks++;
      if (issued_q.size() != 1 || issued_q[0] !== 9'h1FF)
         $display("FAIL top_reads: got %0d reads want exactly one of 1FF", issued_q.size());
      else n_pass++;
   endtask

   task automatic test_error();
      bit ok;
      issued_q.delete();
      xfer_q.delete();
      pulse_start(9'h020, 9'h01F);
      @(negedge clk);
      n_checks++;
      if ({bus.done_o, bus.err_o, bus.busy_o} !== 3'b110)
         $display("FAIL err_start: got done/err/busy=%b want 110", {bus.done_o, bus.err_o, bus.busy_o});
      else n_pass++;
      @(negedge clk); #1;
      n_checks++;
      if ({bus.done_o, bus.err_o} !== 2'b01 || issued_q.size() != 0)
         $display("FAIL err_sticky: got done/err=%b reads=%0d want 01 reads=0", {bus.done_o, bus.err_o}, issued_q.size());
      else n_pass++;
      pulse_start(9'h005, 9'h005);
      @(negedge clk);
      n_checks++;
      if ({bus.err_o, bus.busy_o} !== 2'b01)
         $display("FAIL err_clear: got err/busy=%b want 01", {bus.err_o, bus.busy_o});
      else n_pass++;
      wait_done(20, 1'b0, ok);
      #1;
      n_checks++;
      if (!ok || xfer_q.size() != 1 || xfer_q[0] !== {1'b1, sram_word(9'h005)})
         $display("FAIL err_recover: got done=%b n=%0d want one word of 005", ok, xfer_q.size());
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok;
      int base;
      issued_q.delete();
      xfer_q.delete();
      bus.m_ready_i = 1'b1;
      pulse_start(9'h040, 9'h047);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); #1;
         if (xfer_q.size() >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      bus.m_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (!ok || xfer_q.size() != 2 || xfer_q[1] !== {1'b0, sram_word(9'h041)})
         $display("FAIL rstmid_pre: got n=%0d want 2 words 040,041", xfer_q.size());
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.csb_o, bus.m_valid_o, bus.m_last_o, bus.busy_o, bus.done_o, bus.err_o} !== 6'b100000)
         $display("FAIL rstmid_flags: got %b want 100000", {bus.csb_o, bus.m_valid_o, bus.m_last_o, bus.busy_o, bus.done_o, bus.err_o});
      else n_pass++;
      n_checks++;
      if (bus.m_data_o !== 64'h0 || bus.r_addr_o !== 9'h000)
         $display("FAIL rstmid_data: got data=%h addr=%h want 0/0", bus.m_data_o, bus.r_addr_o);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.m_ready_i = 1'b1;
      issued_q.delete();
      base = valid_cnt;
      repeat (10) @(negedge clk);
      #1;
      n_checks++;
      if (valid_cnt != base || issued_q.size() != 0)
         $display("FAIL rstmid_quiet: got valid cycles=%0d reads=%0d want 0/0", valid_cnt - base, issued_q.size());
      else n_pass++;
   endtask

   task automatic test_restart_ignored();
      bit ok;
      logic [MEM_WORD_SIZE:0] exp_w;
      issued_q.delete();
      xfer_q.delete();
      bus.m_ready_i = 1'b1;
      pulse_start(9'h030, 9'h035);
      @(posedge clk); #1;
      bus.m_ready_i = 1'b0;
      pulse_start(9'h100, 9'h101);
      wait_done(80, 1'b1, ok);
      n_checks++;
      if (!ok || bus.err_o !== 1'b0) $display("FAIL restart_done: got done=%b err=%b want 1/0", ok, bus.err_o);
      else n_pass++;
      #1;
      n_checks++;
      if (xfer_q.size() != 6) $display("FAIL restart_count: got %0d words want 6", xfer_q.size());
      else n_pass++;
      for (int k = 0; k < 6; k++) begin
         exp_w = {(k == 5), sram_word(9'(9'h030 + k))};
         n_checks++;
         if (k >= xfer_q.size() || xfer_q[k] !== exp_w || k >= issued_q.size() || issued_q[k] !== 9'(9'h030 + k))
            $display("FAIL restart_word%0d: got %h want %h", k, (k < xfer_q.size()) ? xfer_q[k] : 65'h0, exp_w);
         else n_pass++;
      end
      n_checks++;
      if (issued_q.size() != 6 || stab_viol != 0 || occ_viol != 0)
         $display("FAIL restart_rules: got reads=%0d stall=%0d credit=%0d want 6/0/0", issued_q.size(), stab_viol, occ_viol);
      else n_pass++;
      bus.m_ready_i = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst              = 1'b1;
      bus.start_i      = 1'b0;
      bus.start_addr_i = '0;
      bus.end_addr_i   = '0;
      bus.m_ready_i    = 1'b0;
      repeat (2) @(posedge clk);
      test_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      test_stream();
      test_backpressure();
      test_top_addr();
      test_error();
      test_reset_mid();
      test_restart_ignored();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
